// File: rtl/chain_code_job_arbiter_if.sv
// Bundles the signals between the job arbiter, the two requester front-ends,
// the shared chain_code_encoder and the result consumer.
//   master : the arbiter side. It drives grant, sel_id, the encoder controls,
//            the result channel, busy, jobs_done and dbg_state.
//   slave  : the environment side. It drives req, the encoder status and
//            result fields, and res_ack.
// Result handshake: res_valid rises with stable res_* data and stays high,
// with that data held, until a cycle in which res_ack=1 is sampled. res_ack
// is ignored whenever res_valid is low.
interface chain_code_job_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        sel_id;
  logic        enc_start;
  logic        enc_rst_n;
  logic        enc_done;
  logic        enc_error;
  logic [8:0]  enc_perimeter;
  logic [11:0] enc_area;
  logic [5:0]  enc_startX;
  logic [5:0]  enc_startY;
  logic        res_valid;
  logic        res_ack;
  logic        res_id;
  logic [1:0]  res_status;
  logic [8:0]  res_perimeter;
  logic [11:0] res_area;
  logic [5:0]  res_startX;
  logic [5:0]  res_startY;
  logic        busy;
  logic [7:0]  jobs_done;
  logic [2:0]  dbg_state;

  modport master (
    input  req, enc_done, enc_error, enc_perimeter, enc_area, enc_startX,
           enc_startY, res_ack,
    output grant, sel_id, enc_start, enc_rst_n, res_valid, res_id, res_status,
           res_perimeter, res_area, res_startX, res_startY, busy, jobs_done,
           dbg_state
  );

  modport slave (
    output req, enc_done, enc_error, enc_perimeter, enc_area, enc_startX,
           enc_startY, res_ack,
    input  grant, sel_id, enc_start, enc_rst_n, res_valid, res_id, res_status,
           res_perimeter, res_area, res_startX, res_startY, busy, jobs_done,
           dbg_state
  );
endinterface

// File: rtl/chain_code_job_arbiter.sv
// Shares one chain_code_encoder between two requesters. The arbiter grants the
// encoder round-robin, pulses enc_start, and waits for enc_done under a
// watchdog. It captures the encoder results and hands them back to the owner
// over the res_valid/res_ack handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    chain_code_job_arbiter_if.master. It carries the requests, the
//          grant, the encoder controls, the result channel, the busy flag,
//          the job counter and the dbg_state FSM view.
module chain_code_job_arbiter #(
  parameter int TIMEOUT      = 8192,
  parameter int TO_W         = 14,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  chain_code_job_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_FLUSH  = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic        last_id_q, last_id_d;
  logic [1:0]  grant_q, grant_d;
  logic        sel_id_q, sel_id_d;
  logic        enc_start_q, enc_start_d;
  logic        enc_rst_n_q, enc_rst_n_d;
  logic        res_valid_q, res_valid_d;
  logic        res_id_q, res_id_d;
  logic [1:0]  res_status_q, res_status_d;
  logic [8:0]  res_perimeter_q, res_perimeter_d;
  logic [11:0] res_area_q, res_area_d;
  logic [5:0]  res_startx_q, res_startx_d;
  logic [5:0]  res_starty_q, res_starty_d;
  logic        busy_q, busy_d;
  logic [7:0]  jobs_done_q, jobs_done_d;
  logic        winner;

  always_comb begin
    // A lone requester wins outright. On a tie, the requester that was not
    // served last wins. req==2'b01 gives 0 and req==2'b10 gives 1.
    winner = (bus.req == 2'b11) ? ~last_id_q : bus.req[1];

    state_d         = state_q;
    timer_d         = timer_q;
    last_id_d       = last_id_q;
    grant_d         = grant_q;
    sel_id_d        = sel_id_q;
    enc_start_d     = 1'b0;
    enc_rst_n_d     = 1'b1;
    res_valid_d     = res_valid_q;
    res_id_d        = res_id_q;
    res_status_d    = res_status_q;
    res_perimeter_d = res_perimeter_q;
    res_area_d      = res_area_q;
    res_startx_d    = res_startx_q;
    res_starty_d    = res_starty_q;
    jobs_done_d     = jobs_done_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          state_d     = S_START;
          grant_d     = winner ? 2'b10 : 2'b01;
          sel_id_d    = winner;
          enc_start_d = 1'b1;
        end
      end
      S_START: begin
        // The START cycle counts as the first cycle of the watchdog window.
        // The window therefore closes exactly TIMEOUT cycles after the start
        // pulse.
        timer_d = TO_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TO_W'(1);
        if (bus.enc_done) begin
          res_perimeter_d = bus.enc_perimeter;
          res_area_d      = bus.enc_area;
          res_startx_d    = bus.enc_startX;
          res_starty_d    = bus.enc_startY;
          res_status_d    = bus.enc_error ? 2'b01 : 2'b00;
          res_valid_d     = 1'b1;
          res_id_d        = sel_id_q;
          state_d         = S_RESULT;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          res_perimeter_d = '0;
          res_area_d      = '0;
          res_startx_d    = '0;
          res_starty_d    = '0;
          res_status_d    = 2'b10;
          enc_rst_n_d     = 1'b0;
          timer_d         = '0;
          state_d         = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The timer counts the cycles in which the encoder reset is held low.
        if (timer_q == TO_W'(FLUSH_CYCLES - 1)) begin
          res_valid_d = 1'b1;
          res_id_d    = sel_id_q;
          state_d     = S_RESULT;
        end else begin
          enc_rst_n_d = 1'b0;
          timer_d     = timer_q + TO_W'(1);
        end
      end
      S_RESULT: begin
        if (bus.res_ack) begin
          res_valid_d = 1'b0;
          grant_d     = 2'b00;
          last_id_d   = sel_id_q;
          jobs_done_d = jobs_done_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      last_id_q       <= 1'b1;
      grant_q         <= 2'b00;
      sel_id_q        <= 1'b0;
      enc_start_q     <= 1'b0;
      enc_rst_n_q     <= 1'b0;
      res_valid_q     <= 1'b0;
      res_id_q        <= 1'b0;
      res_status_q    <= 2'b00;
      res_perimeter_q <= '0;
      res_area_q      <= '0;
      res_startx_q    <= '0;
      res_starty_q    <= '0;
      busy_q          <= 1'b0;
      jobs_done_q     <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      last_id_q       <= last_id_d;
      grant_q         <= grant_d;
      sel_id_q        <= sel_id_d;
      enc_start_q     <= enc_start_d;
      enc_rst_n_q     <= enc_rst_n_d;
      res_valid_q     <= res_valid_d;
      res_id_q        <= res_id_d;
      res_status_q    <= res_status_d;
      res_perimeter_q <= res_perimeter_d;
      res_area_q      <= res_area_d;
      res_startx_q    <= res_startx_d;
      res_starty_q    <= res_starty_d;
      busy_q          <= busy_d;
      jobs_done_q     <= jobs_done_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.sel_id        = sel_id_q;
  assign bus.enc_start     = enc_start_q;
  assign bus.enc_rst_n     = enc_rst_n_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_id        = res_id_q;
  assign bus.res_status    = res_status_q;
  assign bus.res_perimeter = res_perimeter_q;
  assign bus.res_area      = res_area_q;
  assign bus.res_startX    = res_startx_q;
  assign bus.res_startY    = res_starty_q;
  assign bus.busy          = busy_q;
  assign bus.jobs_done     = jobs_done_q;
  assign bus.dbg_state     = state_q;

endmodule
